led_pattern_seq: RTL and testbench

Five-LED pattern sequencer for the Fipsy board. It runs on the internal-oscillator clock (2.08 MHz) and advances one pattern step per `tick` strobe; the top level derives `tick` from its divider as a one-cycle pulse at ~1 Hz. It generates four selectable patterns: binary count, scanner, bar graph and PWM breathing. The registered `led[0:4]` output drives PIN20, PIN14, PIN13, PIN12 and PIN11, in that order.

---
 rtl/led_pattern_pkg.sv | 17 +
 rtl/pwm_gen.sv | 26 ++
 rtl/led_pattern_seq.sv | 107 ++++++++++
 tb/tb_led_pattern_seq.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/led_pattern_pkg.sv
// Shared mode encoding and step end points for the Fipsy five-LED pattern sequencer.
package led_pattern_pkg;

  typedef enum logic [1:0] {
    MODE_BIN     = 2'd0,
    MODE_SCAN    = 2'd1,
    MODE_BAR     = 2'd2,
    MODE_BREATHE = 2'd3
  } mode_e;

  localparam logic [4:0] BIN_MAX  = 5'd31;
  localparam logic [4:0] SCAN_MAX = 5'd4;
  localparam logic [4:0] BAR_MAX  = 5'd5;

  localparam int PWM_BITS_DEFAULT = 4;

endpackage

// File: rtl/pwm_gen.sv
// Free-running PWM counter with a "counter below level" comparator.
module pwm_gen #(
  parameter int PWM_BITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PWM_BITS-1:0] level,
  output logic                on
);

  logic [PWM_BITS-1:0] cnt_q;
  logic [PWM_BITS-1:0] cnt_d;

  assign cnt_d = cnt_q + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign on = (cnt_q < level);

endmodule

// File: rtl/led_pattern_seq.sv
// Five-LED pattern sequencer: BIN count, SCAN, BAR graph and PWM BREATHE,
// stepping once per unpaused tick; led[0] drives PIN20.
module led_pattern_seq
  import led_pattern_pkg::*;
#(
  parameter int PWM_BITS = PWM_BITS_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       pause,
  input  logic [1:0] mode,
  output logic [0:4] led
);

  localparam logic [4:0] BREATHE_MAX = 5'((1 << PWM_BITS) - 1);

  mode_e      cur_mode_q, cur_mode_d;
  logic [4:0] step_q, step_d;
  logic       dir_q, dir_d;
  logic [0:4] led_q, led_d;
  logic [4:0] mode_max;
  logic       adv;
  logic       pwm_on;

  function automatic logic [4:0] step_max(input mode_e m);
    case (m)
      MODE_BIN:  return BIN_MAX;
      MODE_SCAN: return SCAN_MAX;
      MODE_BAR:  return BAR_MAX;
      default:   return BREATHE_MAX;
    endcase
  endfunction

  assign adv      = tick & ~pause;
  assign mode_max = step_max(cur_mode_q);

  always_comb begin
    cur_mode_d = cur_mode_q;
    step_d     = step_q;
    dir_d      = dir_q;
    if (adv) begin
      if (mode_e'(mode) != cur_mode_q) begin
        cur_mode_d = mode_e'(mode);
        step_d     = '0;
        dir_d      = 1'b0;
      end else if (step_q > mode_max) begin
        // Corrupted step (e.g. upset): restart the pattern cleanly.
        step_d = '0;
        dir_d  = 1'b0;
      end else if (cur_mode_q == MODE_BIN) begin
        step_d = step_q + 5'd1;
      end else if (!dir_q) begin
        if (step_q == mode_max) begin
          dir_d  = 1'b1;
          step_d = step_q - 5'd1;
        end else begin
          step_d = step_q + 5'd1;
        end
      end else begin
        if (step_q == 5'd0) begin
          dir_d  = 1'b0;
          step_d = 5'd1;
        end else begin
          step_d = step_q - 5'd1;
        end
      end
    end
  end

  pwm_gen #(
    .PWM_BITS(PWM_BITS)
  ) u_pwm_gen (
    .clk  (clk),
    .rst  (rst),
    .level(step_d[PWM_BITS-1:0]),
    .on   (pwm_on)
  );

  // led is declared [0:4], so the leftmost literal bit lands on led[0].
  always_comb begin
    led_d = '0;
    case (cur_mode_d)
      MODE_BIN:  led_d = step_d;
      MODE_SCAN: led_d = 5'b10000 >> step_d;
      MODE_BAR:  led_d = ~(5'b11111 >> step_d);
      default:   led_d = {5{pwm_on}};
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_mode_q <= MODE_BIN;
      step_q     <= '0;
      dir_q      <= 1'b0;
      led_q      <= '0;
    end else begin
      cur_mode_q <= cur_mode_d;
      step_q     <= step_d;
      dir_q      <= dir_d;
      led_q      <= led_d;
    end
  end

  assign led = led_q;

endmodule

// File: tb/tb_led_pattern_seq.sv
// Self-checking bench for led_pattern_seq: directed vector table, breathing duty
// sequences and a randomized run against a period-based reference model.
module tb_led_pattern_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick = 1'b0;
  logic       pause = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [0:4] led;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: position within the mode's period, plus PWM phase.
  int         m_mode = 0;
  int         m_k    = 0;
  int         m_pwm  = 0;
  logic [0:4] m_led  = '0;

  typedef struct {
    bit         rst;
    bit         tick;
    bit         pause;
    logic [1:0] mode;
    logic [0:4] exp;
  } vec_t;

  vec_t vecs[$];

  led_pattern_seq #(.PWM_BITS(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .tick (tick),
    .pause(pause),
    .mode (mode),
    .led  (led)
  );

  always #5 clk = ~clk;

  function automatic int period_of(input int md);
    case (md)
      0:       return 32;
      1:       return 8;
      2:       return 10;
      default: return 30;
    endcase
  endfunction

  function automatic int step_of(input int md, input int k);
    int half;
    if (md == 0) return k;
    half = period_of(md) / 2;
    return (k <= half) ? k : period_of(md) - k;
  endfunction

  function automatic logic [0:4] decode(input int md, input int st, input int pwm);
    logic [0:4] e;
    for (int i = 0; i < 5; i++) begin
      case (md)
        0:       e[i] = ((st >> (4 - i)) & 1) == 1;
        1:       e[i] = (i == st);
        2:       e[i] = (i < st);
        default: e[i] = (pwm < st);
      endcase
    end
    return e;
  endfunction

  task automatic check(input string name, input logic [0:4] act, input logic [0:4] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: led=%b expected=%b at t=%0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, step the model, compare led after the edge.
  task automatic cycle(input bit r, input bit t, input bit p, input logic [1:0] md);
    @(negedge clk);
    rst = r; tick = t; pause = p; mode = md;
    @(posedge clk);
    #1;
    if (r) begin
      m_mode = 0; m_k = 0; m_pwm = 0; m_led = '0;
    end else begin
      if (t && !p) begin
        if (int'(md) != m_mode) begin
          m_mode = int'(md);
          m_k    = 0;
        end else begin
          m_k = (m_k + 1) % period_of(m_mode);
        end
      end
      m_led = decode(m_mode, step_of(m_mode, m_k), m_pwm);
      m_pwm = (m_pwm + 1) % 16;
    end
    check("model", led, m_led);
  endtask

  function automatic void add(input bit r, input bit t, input bit p, input logic [1:0] md,
                              input logic [0:4] e);
    vec_t v;
    v.rst = r; v.tick = t; v.pause = p; v.mode = md; v.exp = e;
    vecs.push_back(v);
  endfunction

  task automatic duty(input string name, input bit p, input int exp_on);
    int on_cnt;
    on_cnt = 0;
    for (int c = 0; c < 16; c++) begin
      cycle(1'b0, p, p, 2'd3);
      if (led == 5'b11111) on_cnt++;
    end
    n_checks++;
    if (on_cnt != exp_on) begin
      n_fail++;
      $display("FAIL %s: on_cycles=%0d expected=%0d", name, on_cnt, exp_on);
    end
  endtask

  initial begin
    // Reset, then 33 BIN ticks with a hold cycle in between.
    add(1, 0, 0, 2'd0, 5'b00000);
    add(0, 0, 0, 2'd0, 5'b00000);
    for (int i = 1; i <= 33; i++) add(0, 1, 0, 2'd0, 5'(i % 32));
    add(0, 0, 0, 2'd0, 5'b00001);
    // SCAN: first tick is consumed by the mode change.
    add(0, 1, 0, 2'd1, 5'b10000);
    add(0, 1, 0, 2'd1, 5'b01000);
    add(0, 1, 0, 2'd1, 5'b00100);
    add(0, 1, 0, 2'd1, 5'b00010);
    add(0, 1, 0, 2'd1, 5'b00001);
    add(0, 1, 0, 2'd1, 5'b00010);
    add(0, 1, 0, 2'd1, 5'b00100);
    add(0, 1, 0, 2'd1, 5'b01000);
    add(0, 1, 0, 2'd1, 5'b10000);
    // BAR from step 0.
    add(0, 1, 0, 2'd2, 5'b00000);
    add(0, 1, 0, 2'd2, 5'b10000);
    add(0, 1, 0, 2'd2, 5'b11000);
    add(0, 1, 0, 2'd2, 5'b11100);
    add(0, 1, 0, 2'd2, 5'b11110);
    add(0, 1, 0, 2'd2, 5'b11111);
    add(0, 1, 0, 2'd2, 5'b11110);
    add(0, 1, 0, 2'd2, 5'b11100);
    add(0, 1, 0, 2'd2, 5'b11000);
    add(0, 1, 0, 2'd2, 5'b10000);
    add(0, 1, 0, 2'd2, 5'b00000);
    // Pause blocks both stepping and a pending mode change.
    add(0, 1, 0, 2'd1, 5'b10000);
    add(0, 1, 0, 2'd1, 5'b01000);
    add(0, 1, 0, 2'd1, 5'b00100);
    add(0, 1, 0, 2'd1, 5'b00010);
    for (int i = 0; i < 5; i++) add(0, 1, 1, 2'd2, 5'b00010);
    add(0, 1, 0, 2'd2, 5'b00000);
    // Mid-sequence reset at SCAN step 3 overrides a simultaneous tick.
    add(0, 1, 0, 2'd1, 5'b10000);
    add(0, 1, 0, 2'd1, 5'b01000);
    add(0, 1, 0, 2'd1, 5'b00100);
    add(0, 1, 0, 2'd1, 5'b00010);
    add(1, 1, 0, 2'd1, 5'b00000);
    add(0, 1, 0, 2'd0, 5'b00001);

    foreach (vecs[i]) begin
      cycle(vecs[i].rst, vecs[i].tick, vecs[i].pause, vecs[i].mode);
      check($sformatf("vec%0d", i), led, vecs[i].exp);
    end

    // BREATHE duty at levels 8, 15 and 0; level holds while paused.
    cycle(0, 1, 0, 2'd3);
    for (int i = 0; i < 8; i++) cycle(0, 1, 0, 2'd3);
    duty("breathe_l8", 1'b0, 8);
    duty("breathe_l8_paused", 1'b1, 8);
    for (int i = 0; i < 7; i++) cycle(0, 1, 0, 2'd3);
    duty("breathe_l15", 1'b0, 15);
    for (int i = 0; i < 15; i++) cycle(0, 1, 0, 2'd3);
    duty("breathe_l0", 1'b0, 0);

    // Randomized run against the model.
    for (int c = 0; c < 3000; c++) begin
      logic [1:0] md;
      md = mode;
      if ($urandom_range(99) < 4) md = 2'($urandom_range(3));
      cycle($urandom_range(199) == 0, $urandom_range(99) < 35,
            $urandom_range(99) < 20, md);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
